// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module : mc_ctrl_pkg
// Brief  : Shared enums and instruction-field constants for the multi-cycle
//          control sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    localparam int OPC_BITS = 6;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOP = 3'd4
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LW      = 3'd1,
        CLS_SW      = 3'd2,
        CLS_BEQ     = 3'd3,
        CLS_ILLEGAL = 3'd4
    } instr_class_e;

    localparam logic [OPC_BITS-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OPC_BITS-1:0] OPC_LW    = 6'h23;
    localparam logic [OPC_BITS-1:0] OPC_SW    = 6'h2B;
    localparam logic [OPC_BITS-1:0] OPC_BEQ   = 6'h04;

    localparam logic [OPC_BITS-1:0] FN_ADD = 6'h20;
    localparam logic [OPC_BITS-1:0] FN_SUB = 6'h22;
    localparam logic [OPC_BITS-1:0] FN_AND = 6'h24;
    localparam logic [OPC_BITS-1:0] FN_OR  = 6'h25;

endpackage

`default_nettype wire

// File: rtl/mc_instr_decode.sv
// ============================================================================
// Module : mc_instr_decode
// Brief  : Combinational opcode/funct decode into instruction class and ALU op.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_instr_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [OPC_W-1:0] funct,
    output instr_class_e     cls,
    output alu_op_e          op
);

    always_comb begin
        cls = CLS_ILLEGAL;
        op  = ALU_NOP;
        case (opcode)
            OPC_W'(OPC_RTYPE): begin
                case (funct)
                    OPC_W'(FN_ADD): begin cls = CLS_RTYPE; op = ALU_ADD; end
                    OPC_W'(FN_SUB): begin cls = CLS_RTYPE; op = ALU_SUB; end
                    OPC_W'(FN_AND): begin cls = CLS_RTYPE; op = ALU_AND; end
                    OPC_W'(FN_OR):  begin cls = CLS_RTYPE; op = ALU_OR;  end
                    default:        begin cls = CLS_ILLEGAL; op = ALU_NOP; end
                endcase
            end
            OPC_W'(OPC_LW):  begin cls = CLS_LW;  op = ALU_ADD; end
            OPC_W'(OPC_SW):  begin cls = CLS_SW;  op = ALU_ADD; end
            OPC_W'(OPC_BEQ): begin cls = CLS_BEQ; op = ALU_SUB; end
            default:         begin cls = CLS_ILLEGAL; op = ALU_NOP; end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module : mc_control_fsm
// Brief  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with
//          handshake timeout trap. Optional retire counter: MC_CTRL_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int OPC_W       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] instr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        zero_flag,
    output alu_op_e     alu_op,
    output logic        alu_src_reg,
    output logic        ir_load,
    output logic        reg_we,
    output logic        reg_dst_rd,
    output logic        mem_to_reg,
    output logic        pc_inc,
    output logic        pc_branch,
    output logic        retire,
    output logic        trap
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] instret
`endif
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e           r_state;
    state_e           w_state_nxt;
    instr_class_e     r_class;
    alu_op_e          r_op;
    logic [OPC_W-1:0] r_opc;
    logic [OPC_W-1:0] r_fn;
    logic [CNT_W-1:0] r_wait_cnt;

    instr_class_e     w_dec_class;
    alu_op_e          w_dec_op;
    instr_class_e     w_cls;
    alu_op_e          w_op;
    logic             w_fetch_done;
    logic             w_waiting;
    logic             w_timeout;
    logic             w_unused_instr;

    assign w_unused_instr = ^instr[31-OPC_W:OPC_W];

    // Decode runs on the captured instruction so instr need only be valid with imem_ready.
    mc_instr_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opcode (r_opc),
        .funct  (r_fn),
        .cls    (w_dec_class),
        .op     (w_dec_op)
    );

    assign w_fetch_done = (r_state == ST_FETCH) && imem_req && imem_ready;
    assign w_waiting    = ((r_state == ST_FETCH) && imem_req && !imem_ready) ||
                          ((r_state == ST_MEM) && !dmem_ready);
    assign w_timeout    = (MEM_TIMEOUT != 0) && w_waiting && (r_wait_cnt == c_cnt_last);

    assign ir_load   = w_fetch_done;
    assign pc_inc    = w_fetch_done;
    assign pc_branch = (r_state == ST_EXEC) && (r_class == CLS_BEQ) && zero_flag;
    assign retire    = ((r_state == ST_EXEC) && (r_class == CLS_BEQ)) ||
                       ((r_state == ST_MEM) && (r_class == CLS_SW) && dmem_ready) ||
                       (r_state == ST_WB);

    // Outputs are registered from the next state; leaving DECODE the class is not yet latched.
    assign w_cls = (r_state == ST_DECODE) ? w_dec_class : r_class;
    assign w_op  = (r_state == ST_DECODE) ? w_dec_op    : r_op;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_fetch_done)   w_state_nxt = ST_DECODE;
                else if (w_timeout) w_state_nxt = ST_TRAP;
            end
            ST_DECODE: begin
                w_state_nxt = (w_dec_class == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (r_class)
                    CLS_BEQ:         w_state_nxt = ST_FETCH;
                    CLS_RTYPE:       w_state_nxt = ST_WB;
                    CLS_LW, CLS_SW:  w_state_nxt = ST_MEM;
                    default:         w_state_nxt = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready)     w_state_nxt = (r_class == CLS_SW) ? ST_FETCH : ST_WB;
                else if (w_timeout) w_state_nxt = ST_TRAP;
            end
            ST_WB:   w_state_nxt = ST_FETCH;
            ST_TRAP: w_state_nxt = ST_TRAP;
            default: w_state_nxt = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FETCH;
            r_class     <= CLS_ILLEGAL;
            r_op        <= ALU_NOP;
            r_opc       <= '0;
            r_fn        <= '0;
            r_wait_cnt  <= '0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            alu_op      <= ALU_NOP;
            alu_src_reg <= 1'b0;
            reg_we      <= 1'b0;
            reg_dst_rd  <= 1'b0;
            mem_to_reg  <= 1'b0;
            trap        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fetch_done) begin
                r_opc <= instr[31:32-OPC_W];
                r_fn  <= instr[OPC_W-1:0];
            end
            if (r_state == ST_DECODE) begin
                r_class <= w_dec_class;
                r_op    <= w_dec_op;
            end
            if ((w_state_nxt != r_state) &&
                ((w_state_nxt == ST_FETCH) || (w_state_nxt == ST_MEM))) begin
                r_wait_cnt <= '0;
            end else if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            imem_req    <= (w_state_nxt == ST_FETCH);
            dmem_req    <= (w_state_nxt == ST_MEM);
            dmem_we     <= (w_state_nxt == ST_MEM) && (w_cls == CLS_SW);
            alu_op      <= ((w_state_nxt == ST_EXEC) || (w_state_nxt == ST_MEM)) ? w_op : ALU_NOP;
            alu_src_reg <= ((w_state_nxt == ST_EXEC) || (w_state_nxt == ST_MEM)) &&
                           ((w_cls == CLS_RTYPE) || (w_cls == CLS_BEQ));
            reg_we      <= (w_state_nxt == ST_WB);
            reg_dst_rd  <= (w_state_nxt == ST_WB) && (w_cls == CLS_RTYPE);
            mem_to_reg  <= (w_state_nxt == ST_WB) && (w_cls == CLS_LW);
            trap        <= (w_state_nxt == ST_TRAP);
        end
    end

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= 32'd0;
        end else if (retire && (r_state != ST_TRAP)) begin
            instret <= instret + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// Module : tb_mc_control_fsm
// Brief  : Directed scoreboard bench for mc_control_fsm (MEM_TIMEOUT = 4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic    imem_req;
        logic    dmem_req;
        logic    dmem_we;
        alu_op_e alu_op;
        logic    alu_src_reg;
        logic    ir_load;
        logic    reg_we;
        logic    reg_dst_rd;
        logic    mem_to_reg;
        logic    pc_inc;
        logic    pc_branch;
        logic    retire;
        logic    trap;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] instr;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        zero_flag;
    alu_op_e     alu_op;
    logic        alu_src_reg;
    logic        ir_load;
    logic        reg_we;
    logic        reg_dst_rd;
    logic        mem_to_reg;
    logic        pc_inc;
    logic        pc_branch;
    logic        retire;
    logic        trap;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] instret;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    exp_t IDLE, FREQ, FACC, TRAPV;

    localparam logic [31:0] I_ADD = 32'h012A4020;
    localparam logic [31:0] I_LW  = 32'h8D090004;
    localparam logic [31:0] I_SW  = 32'hAD090004;
    localparam logic [31:0] I_BEQ = 32'h11090003;
    localparam logic [31:0] I_ILL = 32'hFC000000;

    mc_control_fsm #(
        .MEM_TIMEOUT (4),
        .OPC_W       (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .zero_flag   (zero_flag),
        .alu_op      (alu_op),
        .alu_src_reg (alu_src_reg),
        .ir_load     (ir_load),
        .reg_we      (reg_we),
        .reg_dst_rd  (reg_dst_rd),
        .mem_to_reg  (mem_to_reg),
        .pc_inc      (pc_inc),
        .pc_branch   (pc_branch),
        .retire      (retire),
        .trap        (trap)
`ifdef MC_CTRL_PERF_EN
        ,
        .instret     (instret)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t E(input logic ireq, dreq, dwe, input alu_op_e op,
                               input logic src, irl, rwe, rd, m2r, pci, pcb, ret, trp);
        exp_t e;
        e.imem_req = ireq;   e.dmem_req = dreq;  e.dmem_we = dwe;
        e.alu_op = op;       e.alu_src_reg = src; e.ir_load = irl;
        e.reg_we = rwe;      e.reg_dst_rd = rd;   e.mem_to_reg = m2r;
        e.pc_inc = pci;      e.pc_branch = pcb;   e.retire = ret;
        e.trap = trp;
        return e;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step(input logic rn, imr, dmr, zf, input logic [31:0] ins,
                        input string tag, input exp_t e);
        exp_t got, want;
        @(negedge clk);
        rst_n = rn; imem_ready = imr; dmem_ready = dmr; zero_flag = zf; instr = ins;
        sb.push_back(e);
        #1;
        got = E(imem_req, dmem_req, dmem_we, alu_op, alu_src_reg, ir_load, reg_we,
                reg_dst_rd, mem_to_reg, pc_inc, pc_branch, retire, trap);
        want = sb.pop_front();
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 32'h0, "rst_hold", IDLE);
        step(1, 0, 0, 0, 32'h0, "rst_rel",  IDLE);
    endtask

    initial begin
        logic [31:0] rt_list [3];
        alu_op_e     op_list [3];
        rt_list = '{32'h012A4022, 32'h012A4024, 32'h012A4025};
        op_list = '{ALU_SUB, ALU_AND, ALU_OR};

        IDLE  = E(0,0,0,ALU_NOP,0,0,0,0,0,0,0,0,0);
        FREQ  = E(1,0,0,ALU_NOP,0,0,0,0,0,0,0,0,0);
        FACC  = E(1,0,0,ALU_NOP,0,1,0,0,0,1,0,0,0);
        TRAPV = E(0,0,0,ALU_NOP,0,0,0,0,0,0,0,0,1);

        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; zero_flag = 1'b0; instr = '0;
        do_reset();

        // add; stray dmem_ready outside MEM must be ignored
        step(1, 1, 0, 0, I_ADD, "add_fetch", FACC);
        step(1, 0, 1, 0, 32'h0, "add_dec",   IDLE);
        step(1, 0, 1, 0, 32'h0, "add_exec",  E(0,0,0,ALU_ADD,1,0,0,0,0,0,0,0,0));
        step(1, 0, 0, 0, 32'h0, "add_wb",    E(0,0,0,ALU_NOP,0,0,1,1,0,0,0,1,0));

        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, rt_list[i], "rt_fetch", FACC);
            step(1, 0, 0, 0, 32'h0,      "rt_dec",   IDLE);
            step(1, 0, 0, 0, 32'h0,      "rt_exec",  E(0,0,0,op_list[i],1,0,0,0,0,0,0,0,0));
            step(1, 0, 0, 0, 32'h0,      "rt_wb",    E(0,0,0,ALU_NOP,0,0,1,1,0,0,0,1,0));
        end

        // lw with dmem_ready three cycles late
        step(1, 1, 0, 0, I_LW, "lw_fetch", FACC);
        step(1, 0, 0, 0, 32'h0, "lw_dec",  IDLE);
        step(1, 0, 0, 0, 32'h0, "lw_exec", E(0,0,0,ALU_ADD,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 32'h0, "lw_mem_wait", E(0,1,0,ALU_ADD,0,0,0,0,0,0,0,0,0));
        step(1, 0, 1, 0, 32'h0, "lw_mem_rdy", E(0,1,0,ALU_ADD,0,0,0,0,0,0,0,0,0));
        step(1, 0, 0, 0, 32'h0, "lw_wb",      E(0,0,0,ALU_NOP,0,0,1,0,1,0,0,1,0));

        // beq taken then not taken
        step(1, 1, 0, 0, I_BEQ, "beq1_fetch", FACC);
        step(1, 0, 0, 0, 32'h0, "beq1_dec",   IDLE);
        step(1, 0, 0, 1, 32'h0, "beq1_exec",  E(0,0,0,ALU_SUB,1,0,0,0,0,0,1,1,0));
        step(1, 1, 0, 0, I_BEQ, "beq0_fetch", FACC);
        step(1, 0, 0, 0, 32'h0, "beq0_dec",   IDLE);
        step(1, 0, 0, 0, 32'h0, "beq0_exec",  E(0,0,0,ALU_SUB,1,0,0,0,0,0,0,1,0));

        // sw with immediate dmem_ready
        step(1, 1, 0, 0, I_SW, "sw_fetch", FACC);
        step(1, 0, 0, 0, 32'h0, "sw_dec",  IDLE);
        step(1, 0, 0, 0, 32'h0, "sw_exec", E(0,0,0,ALU_ADD,0,0,0,0,0,0,0,0,0));
        step(1, 0, 1, 0, 32'h0, "sw_mem",  E(0,1,1,ALU_ADD,0,0,0,0,0,0,0,1,0));
        step(1, 0, 0, 0, 32'h0, "sw_next", FREQ);

        // illegal opcode traps; trap is sticky and blocks all requests
        do_reset();
        step(1, 1, 0, 0, I_ILL, "ill_fetch", FACC);
        step(1, 0, 0, 0, 32'h0, "ill_dec",   IDLE);
        for (int i = 0; i < 5; i++)
            step(1, 1, 1, 1, I_SW, "trap_hold", TRAPV);
        step(0, 0, 0, 0, 32'h0, "trap_clr", IDLE);
        step(1, 0, 0, 0, 32'h0, "trap_rel", IDLE);

        // fetch timeout after 4 waiting cycles
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 32'h0, "to_wait", FREQ);
        step(1, 0, 0, 0, 32'h0, "to_trap", TRAPV);

        // ready on the 4th waiting cycle wins over the timeout
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 32'h0, "late_wait", FREQ);
        step(1, 1, 0, 0, I_ADD, "late_acc",  FACC);
        step(1, 0, 0, 0, 32'h0, "late_dec",  IDLE);
        step(1, 0, 0, 0, 32'h0, "late_exec", E(0,0,0,ALU_ADD,1,0,0,0,0,0,0,0,0));

        // MEM timeout; wait counter restarts on entry to MEM
        do_reset();
        step(1, 0, 0, 0, 32'h0, "mto_fwait", FREQ);
        step(1, 0, 0, 0, 32'h0, "mto_fwait", FREQ);
        step(1, 1, 0, 0, I_LW,  "mto_fetch", FACC);
        step(1, 0, 0, 0, 32'h0, "mto_dec",   IDLE);
        step(1, 0, 0, 0, 32'h0, "mto_exec",  E(0,0,0,ALU_ADD,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 32'h0, "mto_mwait", E(0,1,0,ALU_ADD,0,0,0,0,0,0,0,0,0));
        step(1, 0, 0, 0, 32'h0, "mto_trap", TRAPV);

        // asynchronous reset in the middle of a store
        do_reset();
        step(1, 1, 0, 0, I_SW, "ar_fetch", FACC);
        step(1, 0, 0, 0, 32'h0, "ar_dec",  IDLE);
        step(1, 0, 0, 0, 32'h0, "ar_exec", E(0,0,0,ALU_ADD,0,0,0,0,0,0,0,0,0));
        step(1, 0, 0, 0, 32'h0, "ar_mem",  E(0,1,1,ALU_ADD,0,0,0,0,0,0,0,0,0));
        step(0, 0, 1, 0, 32'h0, "ar_abort", IDLE);
        step(1, 0, 0, 0, 32'h0, "ar_rel",   IDLE);
        step(1, 0, 0, 0, 32'h0, "ar_refetch", FREQ);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle control sequencer that drives the ALU's operation select and operand mux, and consumes its zero flag. Fetches one instruction over an instruction-memory handshake, decodes it, then sequences the execute, memory and writeback steps. Emits register-file, PC and data-memory controls. Supported instructions: add, sub, and, or, lw, sw, beq.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for imem_ready/dmem_ready before trapping; 0 disables the timeout.
OPC_W, 6, opcode/funct field width (fixed MIPS-style encoding).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch complete; instr valid this cycle
instr  in  32  instruction word: opcode [31:26], funct [5:0]
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load
dmem_ready  in  1  data access complete
zero_flag  in  1  ALU zero flag, beq only
alu_op  out  3  alu_op_e: ADD, SUB, AND, OR, NOP
alu_src_reg  out  1  ALU operand-2 mux: 1 = register, 0 = immediate
ir_load  out  1  latch instr into the instruction register
reg_we  out  1  register-file write enable
reg_dst_rd  out  1  1 = rd destination (R-type), 0 = rt
mem_to_reg  out  1  writeback source is load data
pc_inc  out  1  PC <= PC + 4
pc_branch  out  1  PC <= branch target
retire  out  1  one-cycle pulse per completed instruction
trap  out  1  sticky: illegal instruction or timeout

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All outputs reset to 0 and alu_op resets to NOP. State resets to FETCH. Reset asserted mid-instruction aborts the instruction with no writes.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: imem_req = 1, held until imem_ready.
  - On imem_ready: ir_load = 1 and pc_inc = 1 in that same cycle, then go to DECODE.
- DECODE: latch the decoded class (RTYPE, LW, SW, BEQ, ILLEGAL) into a register.
  - Legal R-type: opcode 0x00 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or.
  - Other legal opcodes: 0x23 lw, 0x2B sw, 0x04 beq.
  - Anything else goes to TRAP.
- EXEC: drive alu_op and alu_src_reg from the latched class.
  - RTYPE: op from funct, alu_src_reg = 1.
  - LW/SW: ADD, alu_src_reg = 0.
  - BEQ: SUB, alu_src_reg = 1; pc_branch = zero_flag in this same cycle; retire; go to FETCH.
  - RTYPE goes to WB; LW/SW go to MEM.
- MEM: dmem_req = 1, dmem_we = 1 for SW, held until dmem_ready.
  - alu_op and alu_src_reg stay stable throughout MEM.
  - On dmem_ready: SW retires and goes to FETCH; LW goes to WB.
- WB: reg_we = 1 for exactly one cycle.
  - reg_dst_rd = 1 for RTYPE; mem_to_reg = 1 for LW.
  - retire; go to FETCH.
- Minimum latency, fetch-ready to retire inclusive: beq 3, R-type 4, sw 4, lw 5 cycles.
- Timeout: a wait counter clears on entry to FETCH/MEM and increments each cycle that ready is low.
  - When the count reaches MEM_TIMEOUT (MEM_TIMEOUT > 0), go to TRAP.
  - A ready arriving in the same cycle as the timeout wins; no trap.
- TRAP: trap = 1; all requests and write enables stay 0; the state is held until reset.
- Request outputs never drop before their ready arrives. A ready seen outside FETCH/MEM is ignored.
- Exactly one of pc_inc and pc_branch is high in any cycle, or neither.

Optional Feature:
MC_CTRL_PERF_EN
- Defined: add output instret [31:0], counting retire pulses. It resets to 0, wraps from 0xFFFFFFFF to 0, and freezes in TRAP.
- Undefined: no instret port and no counter logic.

Decomposition:
- Package mc_ctrl_pkg holds:
  - alu_op_e (3-bit enum);
  - state_e;
  - instr_class_e;
  - the opcode and funct localparams.
- One sub-module, mc_instr_decode: combinational instr -> instr_class_e plus alu_op_e. It is instantiated by the FSM and registered in DECODE.

Test Plan:
- add: instr 0x012A4020, imem_ready on cycle 1 -> ir_load and pc_inc on cycle 1; alu_op = ADD with alu_src_reg = 1 on cycle 3; reg_we, reg_dst_rd and retire on cycle 4.
- lw 0x8D090004 with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles with dmem_we = 0; then WB with mem_to_reg = 1, reg_we = 1; 8 cycles total.
- beq 0x11090003: zero_flag = 1 in EXEC -> pc_branch = 1 and retire in the same cycle. Rerun with zero_flag = 0 -> pc_branch stays 0.
- Illegal opcode 0x3F, then sw 0xAD090004 -> trap latches; no dmem_req or reg_we for the rest of the test; rst_n low clears trap.
- MEM_TIMEOUT = 4, imem_ready never asserted -> trap after 4 waiting cycles. Separately, ready arriving on the 4th cycle -> no trap.
- rst_n pulsed low mid-MEM of a sw -> dmem_req drops asynchronously; no retire; restart fetch on the first clock after release.
